// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared op codes, FSM states and parameter defaults for cpu_multicycle
package cpu_mc_pkg;
  localparam int WORDSIZE_DEF  = 64;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int DM_DEPTH_DEF  = 256;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_ADDI = 3'b110,
    OP_ILL  = 3'b111
  } op_t;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_MEM, S_WB} state_t;
  function automatic logic is_mem(input op_t op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/cpu_mc_alu.sv
// cpu_mc_alu: combinational ALU; loads, stores and ADDI all compute rs1+imm
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF
) (
  input  op_t                 op,
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  logic [WORDSIZE-1:0] imm,
  output logic [WORDSIZE-1:0] y
);
  // select the operation; wrap-around arithmetic drops carries and borrows
  always_comb
    y = op == OP_ADD ? a + b :
        op == OP_SUB ? a - b :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_ILL ? '0    : a + imm;
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: one command at a time through IDLE/RD/EX/MEM/WB with register file and data memory
module cpu_multicycle
  import cpu_mc_pkg::*;
#(
  parameter int WORDSIZE  = WORDSIZE_DEF,
  parameter int RF_ADDR_W = RF_ADDR_W_DEF,
  parameter int DM_DEPTH  = DM_DEPTH_DEF,
  localparam int DM_AW    = $clog2(DM_DEPTH)
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic                 cpu_cmd_valid,
  output logic                 cpu_cmd_ready,
  input  logic [2:0]           cpu_cmd_op,
  input  logic [RF_ADDR_W-1:0] cpu_cmd_rd,
  input  logic [RF_ADDR_W-1:0] cpu_cmd_rs1,
  input  logic [RF_ADDR_W-1:0] cpu_cmd_rs2,
  input  logic [WORDSIZE-1:0]  cpu_cmd_imm,
  output logic                 cpu_done,
  output logic                 cpu_err,
  output logic [WORDSIZE-1:0]  cpu_result,
  input  logic [RF_ADDR_W-1:0] cpu_dbg_rf_addr,
  output logic [WORDSIZE-1:0]  cpu_dbg_rf_data,
  input  logic [DM_AW-1:0]     cpu_dbg_dm_addr,
  output logic [WORDSIZE-1:0]  cpu_dbg_dm_data
);
  localparam int NREG = 2 ** RF_ADDR_W;
  state_t state, state_n;
  op_t op_q;
  logic [RF_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [WORDSIZE-1:0] imm_q, a_q, b_q, alu_y, fin_res;
  logic [DM_AW-1:0] addr_q;
  logic oob, oob_q, fin, fin_err;
  logic [WORDSIZE-1:0] rf [NREG];
  logic [WORDSIZE-1:0] dm [DM_DEPTH];

  cpu_mc_alu #(.WORDSIZE(WORDSIZE)) u_alu (.op(op_q), .a(a_q), .b(b_q), .imm(imm_q), .y(alu_y));

  assign cpu_cmd_ready   = state == S_IDLE;
  assign cpu_dbg_rf_data = rf[cpu_dbg_rf_addr];
  assign cpu_dbg_dm_data = dm[cpu_dbg_dm_addr];
  assign oob             = alu_y >= WORDSIZE'(DM_DEPTH);

  // next state, plus whether the coming cycle is the done cycle and what it reports
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_res = cpu_result;
    case (state)
      S_IDLE: state_n = cpu_cmd_valid ? S_RD : S_IDLE;
      S_RD: begin
        state_n = S_EX;
        fin     = op_q == OP_ILL;
        fin_err = op_q == OP_ILL;
      end
      S_EX: begin
        state_n = is_mem(op_q) ? S_MEM : op_q == OP_ILL ? S_IDLE : S_WB;
        fin     = op_q != OP_ILL && (op_q != OP_LD || oob);
        fin_err = is_mem(op_q) && oob;
        fin_res = alu_y;
      end
      S_MEM: begin
        state_n = op_q == OP_LD && !oob_q ? S_WB : S_IDLE;
        fin     = op_q == OP_LD && !oob_q;
        fin_res = dm[addr_q];
      end
      default: state_n = S_IDLE;
    endcase
  end

  // control state, command latches, operand/ALU latches and the done/err/result outputs
  always_ff @(posedge cpu_clk or negedge cpu_rst_n)
    if (!cpu_rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      addr_q     <= '0;
      oob_q      <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_result <= '0;
    end else begin
      state    <= state_n;
      cpu_done <= fin;
      if (fin) begin
        cpu_err    <= fin_err;
        cpu_result <= fin_res;
      end
      if (state == S_IDLE && cpu_cmd_valid) begin
        op_q  <= op_t'(cpu_cmd_op);
        rd_q  <= cpu_cmd_rd;
        rs1_q <= cpu_cmd_rs1;
        rs2_q <= cpu_cmd_rs2;
        imm_q <= cpu_cmd_imm;
      end
      if (state == S_RD) begin
        a_q <= rs1_q == '0 ? '0 : rf[rs1_q];
        b_q <= rs2_q == '0 ? '0 : rf[rs2_q];
      end
      if (state == S_EX) begin
        addr_q <= alu_y[DM_AW-1:0];
        oob_q  <= oob;
      end
    end

  // register file: written at the end of WB, x0 never written
  always_ff @(posedge cpu_clk or negedge cpu_rst_n)
    if (!cpu_rst_n)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (state == S_WB && rd_q != '0)
      rf[rd_q] <= cpu_result;

  // data memory: in-range stores written at the end of MEM
  always_ff @(posedge cpu_clk or negedge cpu_rst_n)
    if (!cpu_rst_n)
      for (int i = 0; i < DM_DEPTH; i++) dm[i] <= '0;
    else if (state == S_MEM && op_q == OP_ST && !oob_q)
      dm[addr_q] <= b_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: scoreboard bench with a behavioural reference model of the command set
module tb_cpu_multicycle;
  typedef struct {
    logic        err;
    logic [63:0] res;
    bit          chk;
    int          due;
  } exp_t;

  logic        cpu_clk = 0, cpu_rst_n = 0, cpu_cmd_valid = 0;
  logic        cpu_cmd_ready, cpu_done, cpu_err;
  logic [2:0]  cpu_cmd_op = 0;
  logic [4:0]  cpu_cmd_rd = 0, cpu_cmd_rs1 = 0, cpu_cmd_rs2 = 0, cpu_dbg_rf_addr = 0;
  logic [63:0] cpu_cmd_imm = 0, cpu_result, cpu_dbg_rf_data, cpu_dbg_dm_data;
  logic [7:0]  cpu_dbg_dm_addr = 0;

  logic [63:0] rf_m [32];
  logic [63:0] dm_m [256];
  exp_t expq[$];
  int cyc = 0, n_vec = 0, n_bad = 0;

  cpu_multicycle dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_op(cpu_cmd_op), .cpu_cmd_rd(cpu_cmd_rd), .cpu_cmd_rs1(cpu_cmd_rs1),
    .cpu_cmd_rs2(cpu_cmd_rs2), .cpu_cmd_imm(cpu_cmd_imm),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_result(cpu_result),
    .cpu_dbg_rf_addr(cpu_dbg_rf_addr), .cpu_dbg_rf_data(cpu_dbg_rf_data),
    .cpu_dbg_dm_addr(cpu_dbg_dm_addr), .cpu_dbg_dm_data(cpu_dbg_dm_data)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    for (int i = 0; i < 256; i++) dm_m[i] = '0;
  endfunction

  // architectural effect of one command; t is the handshake cycle
  function automatic exp_t model(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [63:0] imm, input int t);
    exp_t e;
    logic [63:0] a, b, addr;
    a = rs1 == 0 ? 64'd0 : rf_m[rs1];
    b = rs2 == 0 ? 64'd0 : rf_m[rs2];
    addr = a + imm;
    e.err = 0; e.chk = 1; e.res = 0; e.due = t + 3;
    case (op)
      3'd0: e.res = a + b;
      3'd1: e.res = a - b;
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd6: e.res = a + imm;
      3'd4: if (addr >= 256) begin e.err = 1; e.chk = 0; end
            else begin e.res = dm_m[addr[7:0]]; e.due = t + 4; end
      3'd5: if (addr >= 256) begin e.err = 1; e.chk = 0; end
            else begin e.res = addr; dm_m[addr[7:0]] = b; end
      default: begin e.err = 1; e.chk = 0; e.due = t + 2; end
    endcase
    if (!e.err && op != 3'd5 && rd != 0) rf_m[rd] = e.res;
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm);
    cpu_cmd_op = op; cpu_cmd_rd = rd; cpu_cmd_rs1 = rs1; cpu_cmd_rs2 = rs2; cpu_cmd_imm = imm;
    cpu_cmd_valid = 1;
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    @(negedge cpu_clk);
    while (!cpu_cmd_ready && w < 20) begin @(negedge cpu_clk); w++; end
    ok = cpu_cmd_ready;
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL ready_timeout got 0 want 1");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      drive(op, rd, rs1, rs2, imm);
      expq.push_back(model(op, rd, rs1, rs2, imm, cyc));
      @(posedge cpu_clk);
      #1 cpu_cmd_valid = 0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (expq.size() != 0 && w < 60) begin @(negedge cpu_clk); w++; end
    if (expq.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain pending %0d want 0", expq.size());
      expq.delete();
    end
    repeat (2) @(negedge cpu_clk);
  endtask

  task automatic check_state();
    for (int i = 0; i < 32; i++) begin
      @(negedge cpu_clk);
      cpu_dbg_rf_addr = 5'(i);
      #1 chk($sformatf("rf[%0d]", i), cpu_dbg_rf_data, rf_m[i]);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge cpu_clk);
      cpu_dbg_dm_addr = 8'(i);
      #1 chk($sformatf("dm[%0d]", i), cpu_dbg_dm_data, dm_m[i]);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge cpu_clk)
    if (cpu_done) begin
      exp_t e;
      if (expq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("err", {63'd0, cpu_err}, {63'd0, e.err});
        if (e.chk) chk("result", cpu_result, e.res);
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit ok;
    int ta;
    logic [2:0] op;
    logic [63:0] imm;
    model_reset();
    repeat (3) @(negedge cpu_clk);
    #1;
    chk("rst_ready", {63'd0, cpu_cmd_ready}, 64'd1);
    chk("rst_done", {63'd0, cpu_done}, 64'd0);
    cpu_dbg_rf_addr = 7; cpu_dbg_dm_addr = 23;
    #1 chk("rst_x7", cpu_dbg_rf_data, 64'd0);
    chk("rst_m23", cpu_dbg_dm_data, 64'd0);
    @(negedge cpu_clk) cpu_rst_n = 1;

    issue(3'd6, 4, 0, 0, 64'h2A);
    issue(3'd5, 0, 0, 4, 64'd23);
    issue(3'd4, 2, 0, 0, 64'd23);
    issue(3'd1, 1, 0, 2, 64'd0);
    issue(3'd6, 0, 0, 0, 64'd5);
    drain();
    cpu_dbg_dm_addr = 23; cpu_dbg_rf_addr = 1;
    #1 chk("m23", cpu_dbg_dm_data, 64'h2A);
    chk("x1", cpu_dbg_rf_data, 64'hFFFF_FFFF_FFFF_FFD6);

    // second command held valid while the first is in flight
    wait_ready(ok);
    if (ok) begin
      drive(3'd6, 9, 0, 0, 64'd77);
      ta = cyc;
      expq.push_back(model(3'd6, 9, 0, 0, 64'd77, ta));
      @(posedge cpu_clk);
      #1 drive(3'd0, 10, 9, 9, 64'd0);
      expq.push_back(model(3'd0, 10, 9, 9, 64'd0, ta + 4));
      wait_ready(ok);
      @(posedge cpu_clk);
      #1 cpu_cmd_valid = 0;
    end

    issue(3'd4, 3, 0, 0, 64'd256);
    issue(3'd7, 5, 1, 2, 64'd0);
    drain();

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      imm = (op == 3'd4 || op == 3'd5) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      issue(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
      repeat ($urandom_range(0, 2)) @(negedge cpu_clk);
    end
    drain();
    check_state();

    // reset while a store sits in EX
    issue(3'd6, 6, 0, 0, 64'h55);
    drain();
    wait_ready(ok);
    if (ok) begin
      drive(3'd5, 0, 0, 6, 64'd40);
      @(posedge cpu_clk);
      #1 cpu_cmd_valid = 0;
      @(posedge cpu_clk);
      #2 cpu_rst_n = 0;
      model_reset();
      #1 chk("midrst_ready", {63'd0, cpu_cmd_ready}, 64'd1);
      chk("midrst_done", {63'd0, cpu_done}, 64'd0);
      @(negedge cpu_clk) cpu_rst_n = 1;
      repeat (6) @(negedge cpu_clk);
      cpu_dbg_dm_addr = 40; cpu_dbg_rf_addr = 6;
      #1 chk("midrst_m40", cpu_dbg_dm_data, 64'd0);
      chk("midrst_x6", cpu_dbg_rf_data, 64'd0);
      chk("midrst_ready_after", {63'd0, cpu_cmd_ready}, 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data/register/ALU width in bits.
REQ-002 SHALL have parameter RF_ADDR_W, default 5, register index width (2^RF_ADDR_W registers).
REQ-003 SHALL have parameter DM_DEPTH, default 256, data memory depth in words (power of two).
REQ-004 SHALL have port cpu_clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port cpu_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_cmd_valid  in  1  command offered.
REQ-007 SHALL have port cpu_cmd_ready  out  1  block idle, command accepted when valid&ready.
REQ-008 SHALL have port cpu_cmd_op  in  3  operation code.
REQ-009 SHALL have ports cpu_cmd_rd, cpu_cmd_rs1, cpu_cmd_rs2  in  RF_ADDR_W each  destination/source registers.
REQ-010 SHALL have port cpu_cmd_imm  in  WORDSIZE  immediate.
REQ-011 SHALL have port cpu_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port cpu_err  out  1  valid with cpu_done: command aborted.
REQ-013 SHALL have port cpu_result  out  WORDSIZE  ALU result or loaded word, valid with cpu_done.
REQ-014 SHALL have ports cpu_dbg_rf_addr in RF_ADDR_W / cpu_dbg_rf_data out WORDSIZE  combinational register read.
REQ-015 SHALL have ports cpu_dbg_dm_addr in log2(DM_DEPTH) / cpu_dbg_dm_data out WORDSIZE  combinational memory read.

Function
REQ-016 SHALL decode op: 000 ADD rs1+rs2, 001 SUB rs1-rs2, 010 AND, 011 OR, 100 LD rd=mem[rs1+imm], 101 ST mem[rs1+imm]=rs2, 110 ADDI rs1+imm, 111 illegal.
REQ-017 SHALL implement FSM states IDLE, RD, EX, MEM, WB; cpu_cmd_ready = (state==IDLE).
REQ-018 SHALL on handshake in cycle T latch op/rd/rs1/rs2/imm and enter RD at T+1; cpu_cmd_valid while not ready ignored.
REQ-019 SHALL in RD latch rs1/rs2 register values; register 0 always reads 0.
REQ-020 SHALL in EX latch ALU result; arithmetic modulo 2^WORDSIZE, carries/borrows discarded.
REQ-021 SHALL route ALU ops EX->WB: cpu_done at T+3, register write at end of WB.
REQ-022 SHALL route LD EX->MEM->WB: read in MEM, cpu_done and register write at T+4.
REQ-023 SHALL route ST EX->MEM: cpu_done at T+3, memory write at end of MEM, cpu_result = store address.
REQ-024 SHALL treat address as word index; if address >= DM_DEPTH, LD/ST SHALL assert cpu_done+cpu_err in MEM (T+3) with no memory or register write.
REQ-025 SHALL for op 111 assert cpu_done+cpu_err in EX (T+2), no writes.
REQ-026 SHALL discard writes to register 0 without error.
REQ-027 SHALL return to IDLE the cycle after cpu_done; back-to-back commands accepted then.
REQ-028 SHALL hold cpu_result/cpu_err stable until the next cpu_done; cpu_err 0 on success.

Reset
REQ-029 SHALL on cpu_rst_n low immediately force state IDLE, cpu_done 0, cpu_err 0, cpu_result 0, all registers and memory words 0; cpu_cmd_ready 1.
REQ-030 SHALL on reset mid-operation abandon the command: no pending register/memory write, no cpu_done.

Structure
REQ-031 SHALL place op encodings, FSM state encoding and parameter defaults in shared package cpu_mc_pkg.
REQ-032 SHALL implement ALU as sub-module cpu_mc_alu (combinational, WORDSIZE-parametrised).

Verification
REQ-033 Reset -> cpu_cmd_ready=1, cpu_done=0, dbg reads of x7 and mem[23] = 0.
REQ-034 ADDI x4,x0,0x2A then ST x4,23(x0) -> done at T+3, result 0x2A; then mem[23]=0x2A, done at T+3, cpu_err=0.
REQ-035 LD x2,23(x0) -> done at T+4, cpu_result=0x2A, x2=0x2A; SUB x1,x0,x2 -> x1=0xFFFF_FFFF_FFFF_FFD6 at T+3.
REQ-036 ADDI x0,x0,5 -> done, x0 stays 0; second valid held during busy -> accepted only after return to IDLE.
REQ-037 LD x3,256(x0) -> done+err at T+3, x3 unchanged; op 111 -> done+err at T+2.
REQ-038 ST issued, cpu_rst_n pulsed low in EX -> no done, target memory word 0, ready=1 after release.
